// File: rtl/periph_xbar_pkg.sv
// Shared constants and the address-rule helper for the peripheral crossbar.
package periph_xbar_pkg;

    localparam int unsigned ADDR_MAX = 64;
    typedef logic [ADDR_MAX-1:0] addr_t;

    localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

    // A rule with start above end can never match, which is how rules are disabled.
    function automatic logic addr_match(input addr_t addr, input addr_t start_addr, input addr_t end_addr);
        return (start_addr <= addr) && (addr <= end_addr);
    endfunction

endpackage

// File: rtl/periph_xbar_rr_arb.sv
// Combinational round-robin picker: first requester found after ptr, wrapping.
module periph_xbar_rr_arb #(
    parameter  int N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic found_s;

    // Scan ptr+1, ptr+2, ... ptr (mod N) and keep the first hit.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        found_s = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found_s && req[(int'(ptr) + k) % N]) begin
                found_s                   = 1'b1;
                gnt[(int'(ptr) + k) % N]  = 1'b1;
                idx                       = IW'((int'(ptr) + k) % N);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/periph_xbar.sv
// Request/grant crossbar: runtime address map, per-slave round-robin, one outstanding
// transaction per master and per slave, and an internal decode-error responder.
module periph_xbar
    import periph_xbar_pkg::*;
#(
    parameter int NB_MASTER  = 3,
    parameter int NB_SLAVE   = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NB_SLAVE*ADDR_WIDTH-1:0]   start_addr_i,
    input  logic [NB_SLAVE*ADDR_WIDTH-1:0]   end_addr_i,
    input  logic [NB_MASTER-1:0]             m_req_i,
    output logic [NB_MASTER-1:0]             m_gnt_o,
    input  logic [NB_MASTER*ADDR_WIDTH-1:0]  m_addr_i,
    input  logic [NB_MASTER-1:0]             m_we_i,
    input  logic [NB_MASTER*DATA_WIDTH/8-1:0] m_be_i,
    input  logic [NB_MASTER*DATA_WIDTH-1:0]  m_wdata_i,
    output logic [NB_MASTER-1:0]             m_rvalid_o,
    output logic [NB_MASTER*DATA_WIDTH-1:0]  m_rdata_o,
    output logic [NB_MASTER-1:0]             m_err_o,
    output logic [NB_SLAVE-1:0]              s_req_o,
    input  logic [NB_SLAVE-1:0]              s_gnt_i,
    output logic [NB_SLAVE*ADDR_WIDTH-1:0]   s_addr_o,
    output logic [NB_SLAVE-1:0]              s_we_o,
    output logic [NB_SLAVE*DATA_WIDTH/8-1:0] s_be_o,
    output logic [NB_SLAVE*DATA_WIDTH-1:0]   s_wdata_o,
    input  logic [NB_SLAVE-1:0]              s_rvalid_i,
    input  logic [NB_SLAVE*DATA_WIDTH-1:0]   s_rdata_i,
    input  logic [NB_SLAVE-1:0]              s_err_i
);

    localparam int MW = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
    localparam int BW = DATA_WIDTH / 8;
    localparam int NT = NB_SLAVE + 1;  // target NB_SLAVE is the error slave
    localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_RDATA);

    logic [NT-1:0]        dec_s     [NB_MASTER];
    logic [NB_MASTER-1:0] arb_req_s [NT];
    logic [NB_MASTER-1:0] arb_gnt_s [NT];
    logic [MW-1:0]        arb_idx_s [NT];
    logic [NB_SLAVE-1:0]  slv_ok_s;
    logic [NB_SLAVE-1:0]  rsp_s;
    logic [NB_SLAVE-1:0]  hs_s;
    logic                 err_win_s;

    logic [NB_MASTER-1:0] m_busy_r;
    logic [NB_SLAVE-1:0]  s_busy_r;
    logic [MW-1:0]        owner_r [NB_SLAVE];
    logic [MW-1:0]        ptr_r   [NT];
    logic                 err_busy_r;
    logic [MW-1:0]        err_owner_r;

    // One-hot target per master; scanning downward lets the lowest matching rule win.
    always_comb begin
        for (int m = 0; m < NB_MASTER; m++) begin
            dec_s[m] = NT'(1'b1) << NB_SLAVE;
            for (int j = NB_SLAVE - 1; j >= 0; j--) begin
                if (addr_match(addr_t'(m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH]),
                               addr_t'(start_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH]),
                               addr_t'(end_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH]))) begin
                    dec_s[m] = NT'(1'b1) << j;
                end else begin
                    dec_s[m] = dec_s[m];
                end
            end
        end
    end

    // Busy masters are hidden from every arbiter until their response returns.
    always_comb begin
        for (int t = 0; t < NT; t++) begin
            for (int m = 0; m < NB_MASTER; m++) begin
                arb_req_s[t][m] = m_req_i[m] & ~m_busy_r[m] & dec_s[m][t];
            end
        end
    end

    for (genvar t = 0; t < NT; t++) begin : g_arb
        periph_xbar_rr_arb #(.N(NB_MASTER)) u_arb (
            .req (arb_req_s[t]),
            .ptr (ptr_r[t]),
            .gnt (arb_gnt_s[t]),
            .idx (arb_idx_s[t])
        );
    end

    // A response in the same cycle frees the slave for a back-to-back grant.
    assign slv_ok_s  = ~s_busy_r | s_rvalid_i;
    assign rsp_s     = s_busy_r & s_rvalid_i;
    assign err_win_s = rst_n & (|arb_gnt_s[NB_SLAVE]);

    // Forward the winner's request and payload to each slave port.
    always_comb begin
        s_req_o   = '0;
        s_addr_o  = '0;
        s_we_o    = '0;
        s_be_o    = '0;
        s_wdata_o = '0;
        hs_s      = '0;
        for (int j = 0; j < NB_SLAVE; j++) begin
            if (rst_n && slv_ok_s[j] && (|arb_gnt_s[j])) begin
                s_req_o[j]                                = 1'b1;
                s_addr_o[j*ADDR_WIDTH +: ADDR_WIDTH]      = m_addr_i[int'(arb_idx_s[j])*ADDR_WIDTH +: ADDR_WIDTH];
                s_we_o[j]                                 = m_we_i[arb_idx_s[j]];
                s_be_o[j*BW +: BW]                        = m_be_i[int'(arb_idx_s[j])*BW +: BW];
                s_wdata_o[j*DATA_WIDTH +: DATA_WIDTH]     = m_wdata_i[int'(arb_idx_s[j])*DATA_WIDTH +: DATA_WIDTH];
                hs_s[j]                                   = s_gnt_i[j];
            end else begin
                hs_s[j] = 1'b0;
            end
        end
    end

    // Grants and responses back to the masters, including the error responder.
    always_comb begin
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        m_err_o    = '0;
        for (int j = 0; j < NB_SLAVE; j++) begin
            if (hs_s[j]) begin
                m_gnt_o[arb_idx_s[j]] = 1'b1;
            end else begin
                m_gnt_o = m_gnt_o;
            end
            if (rsp_s[j]) begin
                m_rvalid_o[owner_r[j]]                               = 1'b1;
                m_rdata_o[int'(owner_r[j])*DATA_WIDTH +: DATA_WIDTH] = s_rdata_i[j*DATA_WIDTH +: DATA_WIDTH];
                m_err_o[owner_r[j]]                                  = s_err_i[j];
            end else begin
                m_rvalid_o = m_rvalid_o;
            end
        end
        if (err_win_s) begin
            m_gnt_o[arb_idx_s[NB_SLAVE]] = 1'b1;
        end else begin
            m_gnt_o = m_gnt_o;
        end
        if (err_busy_r) begin
            m_rvalid_o[err_owner_r]                               = 1'b1;
            m_rdata_o[int'(err_owner_r)*DATA_WIDTH +: DATA_WIDTH] = ERR_DATA;
            m_err_o[err_owner_r]                                  = 1'b1;
        end else begin
            m_rvalid_o = m_rvalid_o;
        end
    end

    // Busy/owner/pointer bookkeeping; clears come first so a same-cycle re-grant wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy_r    <= '0;
            s_busy_r    <= '0;
            err_busy_r  <= 1'b0;
            err_owner_r <= '0;
            for (int j = 0; j < NB_SLAVE; j++) begin
                owner_r[j] <= '0;
            end
            for (int t = 0; t < NT; t++) begin
                ptr_r[t] <= MW'(NB_MASTER - 1);
            end
        end else begin
            for (int j = 0; j < NB_SLAVE; j++) begin
                if (rsp_s[j]) begin
                    m_busy_r[owner_r[j]] <= 1'b0;
                    s_busy_r[j]          <= 1'b0;
                end
                if (hs_s[j]) begin
                    s_busy_r[j]            <= 1'b1;
                    owner_r[j]             <= arb_idx_s[j];
                    ptr_r[j]               <= arb_idx_s[j];
                    m_busy_r[arb_idx_s[j]] <= 1'b1;
                end
            end
            if (err_busy_r) begin
                m_busy_r[err_owner_r] <= 1'b0;
            end
            if (err_win_s) begin
                err_busy_r                    <= 1'b1;
                err_owner_r                   <= arb_idx_s[NB_SLAVE];
                ptr_r[NB_SLAVE]               <= arb_idx_s[NB_SLAVE];
                m_busy_r[arb_idx_s[NB_SLAVE]] <= 1'b1;
            end else begin
                err_busy_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_periph_xbar.sv
// Directed bench for periph_xbar: routing, round-robin, error slave, back-to-back and reset.
module tb_periph_xbar;

    localparam int NM = 3;
    localparam int NS = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NS*AW-1:0]  start_addr_i, end_addr_i;
    logic [NM-1:0]     m_req_i, m_gnt_o, m_we_i, m_rvalid_o, m_err_o;
    logic [NM*AW-1:0]  m_addr_i;
    logic [NM*DW/8-1:0] m_be_i;
    logic [NM*DW-1:0]  m_wdata_i, m_rdata_o;
    logic [NS-1:0]     s_req_o, s_gnt_i, s_we_o, s_rvalid_i, s_err_i;
    logic [NS*AW-1:0]  s_addr_o;
    logic [NS*DW/8-1:0] s_be_o;
    logic [NS*DW-1:0]  s_wdata_o, s_rdata_i;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_v;

    always #5 clk = ~clk;

    periph_xbar #(.NB_MASTER(NM), .NB_SLAVE(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_addr_i(start_addr_i), .end_addr_i(end_addr_i),
        .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
        .m_be_i(m_be_i), .m_wdata_i(m_wdata_i), .m_rvalid_o(m_rvalid_o),
        .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
        .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
        .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i),
        .s_rdata_i(s_rdata_i), .s_err_i(s_err_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic req, input logic [AW-1:0] addr,
                         input logic we, input logic [DW-1:0] wdata);
        m_req_i[m]             = req;
        m_addr_i[m*AW +: AW]   = addr;
        m_we_i[m]              = we;
        m_wdata_i[m*DW +: DW]  = wdata;
    endtask

    task automatic default_map();
        start_addr_i = {32'h1A10_0000, 32'h0010_0000, 32'h0000_0000};
        end_addr_i   = {32'h1A11_FFFF, 32'h001F_FFFF, 32'h000F_FFFF};
    endtask

    initial begin
        rst_n      = 1'b0;
        default_map();
        m_req_i    = 3'b111;
        m_addr_i   = '0;
        m_we_i     = 3'b000;
        m_be_i     = '1;
        m_wdata_i  = '0;
        s_gnt_i    = 3'b111;
        s_rvalid_i = 3'b000;
        s_rdata_i  = '0;
        s_err_i    = 3'b000;
        #2;
        check("rst_s_req", s_req_o, 3'b000);
        check("rst_m_gnt", m_gnt_o, 3'b000);
        check("rst_m_rvalid", m_rvalid_o, 3'b000);
        check("rst_s_addr", s_addr_o, 96'h0);
        tick();
        m_req_i = 3'b000;
        rst_n   = 1'b1;

        // Single read to slave 1, response two cycles later.
        tick();
        set_m(0, 1'b1, 32'h0010_0004, 1'b0, 32'h0);
        #1;
        check("t1_s_req", s_req_o, 3'b010);
        check("t1_m_gnt", m_gnt_o, 3'b001);
        check("t1_s_addr", s_addr_o[1*AW +: AW], 32'h0010_0004);
        check("t1_s_be", s_be_o[4 +: 4], 4'hF);
        tick();
        set_m(0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("t1_idle_rvalid", m_rvalid_o, 3'b000);
        tick();
        s_rvalid_i = 3'b010;
        s_rdata_i[1*DW +: DW] = 32'h0000_1234;
        #1;
        check("t1_rvalid", m_rvalid_o, 3'b001);
        check("t1_rdata", m_rdata_o[0 +: DW], 32'h0000_1234);
        check("t1_err", m_err_o, 3'b000);
        tick();
        s_rvalid_i = 3'b000;

        // Three masters hammer slave 0 (1-cycle latency): grants rotate 0,1,2,0,1.
        set_m(0, 1'b1, 32'h10, 1'b0, 32'h0);
        set_m(1, 1'b1, 32'h20, 1'b0, 32'h0);
        set_m(2, 1'b1, 32'h30, 1'b0, 32'h0);
        #1;
        check("rr_first_gnt", m_gnt_o, 3'b001);
        check("rr_first_addr", s_addr_o[0 +: AW], 32'h10);
        for (int k = 0; k < 4; k++) begin
            tick();
            s_rvalid_i = 3'b001;
            s_rdata_i[0 +: DW] = 32'hA0 + k;
            #1;
            exp_v = 3'b001 << (k % 3);
            check("rr_rvalid", m_rvalid_o, exp_v);
            check("rr_rdata", m_rdata_o[(k % 3)*DW +: DW], 32'hA0 + k);
            exp_v = 3'b001 << ((k + 1) % 3);
            check("rr_gnt", m_gnt_o, exp_v);
        end
        tick();
        m_req_i = 3'b000;
        s_rdata_i[0 +: DW] = 32'hA4;
        #1;
        check("rr_last_rvalid", m_rvalid_o, 3'b010);
        check("rr_last_rdata", m_rdata_o[1*DW +: DW], 32'hA4);
        check("rr_last_gnt", m_gnt_o, 3'b000);
        tick();
        #1;
        check("spurious_rvalid", m_rvalid_o, 3'b000);
        tick();
        s_rvalid_i = 3'b000;

        // Unmapped address goes to the error slave.
        set_m(1, 1'b1, 32'h2000_0000, 1'b0, 32'h0);
        #1;
        check("err_gnt", m_gnt_o, 3'b010);
        check("err_no_s_req", s_req_o, 3'b000);
        tick();
        set_m(1, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("err_rvalid", m_rvalid_o, 3'b010);
        check("err_err", m_err_o, 3'b010);
        check("err_rdata", m_rdata_o[1*DW +: DW], 32'hBADACCE5);
        tick();
        check("err_done", m_rvalid_o, 3'b000);

        // Overlapping rules, then a disabled rule.
        s_gnt_i = 3'b000;
        start_addr_i[2*AW +: AW] = 32'h0;
        end_addr_i[2*AW +: AW]   = 32'h1FF;
        set_m(2, 1'b1, 32'h100, 1'b0, 32'h0);
        #1;
        check("ovl_s_req", s_req_o, 3'b001);
        check("ovl_s_addr", s_addr_o[0 +: AW], 32'h100);
        check("ovl_no_gnt", m_gnt_o, 3'b000);
        start_addr_i[0 +: AW] = 32'h200;
        end_addr_i[0 +: AW]   = 32'h100;
        #1;
        check("dis_s_req", s_req_o, 3'b100);
        check("dis_s_addr", s_addr_o[2*AW +: AW], 32'h100);
        tick();
        set_m(2, 1'b0, 32'h0, 1'b0, 32'h0);
        default_map();
        s_gnt_i = 3'b111;

        // Back-to-back on slave 1: response to master 0 and grant to master 2 together.
        tick();
        set_m(0, 1'b1, 32'h0010_0000, 1'b0, 32'h0);
        #1;
        check("b2b_gnt0", m_gnt_o, 3'b001);
        tick();
        set_m(0, 1'b0, 32'h0, 1'b0, 32'h0);
        set_m(2, 1'b1, 32'h0010_0008, 1'b1, 32'h0000_CAFE);
        #1;
        check("b2b_blocked_req", s_req_o, 3'b000);
        check("b2b_blocked_gnt", m_gnt_o, 3'b000);
        tick();
        s_rvalid_i = 3'b010;
        s_rdata_i[1*DW +: DW] = 32'h55;
        #1;
        check("b2b_rvalid_old", m_rvalid_o, 3'b001);
        check("b2b_rdata_old", m_rdata_o[0 +: DW], 32'h55);
        check("b2b_gnt_new", m_gnt_o, 3'b100);
        check("b2b_we", s_we_o, 3'b010);
        check("b2b_wdata", s_wdata_o[1*DW +: DW], 32'h0000_CAFE);
        tick();
        set_m(2, 1'b0, 32'h0, 1'b0, 32'h0);
        s_rdata_i[1*DW +: DW] = 32'h66;
        #1;
        check("b2b_rvalid_new", m_rvalid_o, 3'b100);
        check("b2b_rdata_new", m_rdata_o[2*DW +: DW], 32'h66);
        check("b2b_err_new", m_err_o, 3'b000);
        tick();
        s_rvalid_i = 3'b000;

        // Reset while slave 1 is busy; a late response must be dropped.
        set_m(1, 1'b1, 32'h0010_0010, 1'b0, 32'h0);
        #1;
        check("rst_mid_gnt", m_gnt_o, 3'b010);
        tick();
        set_m(1, 1'b0, 32'h0, 1'b0, 32'h0);
        set_m(0, 1'b1, 32'h0010_0000, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_s_req", s_req_o, 3'b000);
        check("rst_mid_m_gnt", m_gnt_o, 3'b000);
        tick();
        rst_n = 1'b1;
        set_m(0, 1'b0, 32'h0, 1'b0, 32'h0);
        s_rvalid_i = 3'b010;
        s_rdata_i[1*DW +: DW] = 32'h77;
        #1;
        check("rst_late_rvalid", m_rvalid_o, 3'b000);
        tick();
        s_rvalid_i = 3'b000;
        set_m(0, 1'b1, 32'h0010_0000, 1'b0, 32'h0);
        set_m(2, 1'b1, 32'h0010_0008, 1'b0, 32'h0);
        #1;
        check("rst_prio_gnt", m_gnt_o, 3'b001);
        check("rst_prio_addr", s_addr_o[1*AW +: AW], 32'h0010_0000);
        tick();
        m_req_i = 3'b000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
